// File: rtl/hash_pkg.sv
// Shared definitions for the Jenkins lookup3 key path: hash constants, packer FSM state
// and the 96-bit key block handed to the hash rounds.
package hash_pkg;
   localparam logic [31:0] JHASH_INIT = 32'hDEADBEEF;
   localparam int          BLK_BYTES  = 12;
   localparam int          MAXLEN     = 250;
   localparam int          LENW       = 8;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} hkp_state_e;

   typedef struct packed {
      logic [31:0]     k0;
      logic [31:0]     k1;
      logic [31:0]     k2;
      logic [LENW-1:0] rem;
      logic [LENW-1:0] len;
      logic            first;
      logic            last;
   } key_blk_t;
endpackage

// File: rtl/hash_blk_oreg.sv
// Single-entry valid/ready holding register for key blocks headed into the hash rounds.
module hash_blk_oreg
   import hash_pkg::*;
(
   input  logic     CLK,
   input  logic     RST,
   input  logic     load_i,
   input  key_blk_t blk_i,
   input  logic     ready_i,
   output logic     valid_o,
   output logic     free_o,
   output key_blk_t blk_o
);
   logic     valid_q, valid_d;
   key_blk_t blk_q, blk_d;

   // Free when empty or draining this cycle, so a new block can load back-to-back.
   assign free_o = !valid_q || ready_i;

   always_comb begin
      valid_d = valid_q && !ready_i;
      blk_d   = blk_q;
      if (load_i) begin
         valid_d = 1'b1;
         blk_d   = blk_i;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= 1'b0;
         blk_q   <= '0;
      end else begin
         valid_q <= valid_d;
         blk_q   <= blk_d;
      end
   end

   assign valid_o = valid_q;
   assign blk_o   = blk_q;
endmodule

// File: rtl/hash_key_packer.sv
// Packs a length-prefixed 32-bit key byte stream into lookup3 k0/k1/k2 blocks,
// tagging each with the remaining byte count and flagging length mismatches.
module hash_key_packer #(
   parameter int MAXLEN = hash_pkg::MAXLEN,
   parameter int LENW   = hash_pkg::LENW
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [LENW-1:0] hdr_len,
   input  logic            hdr_valid,
   output logic            hdr_ready,
   input  logic [31:0]     s_data,
   input  logic [3:0]      s_keep,
   input  logic            s_last,
   input  logic            s_valid,
   output logic            s_ready,
   output logic [31:0]     m_k0,
   output logic [31:0]     m_k1,
   output logic [31:0]     m_k2,
   output logic [LENW-1:0] m_rem,
   output logic [LENW-1:0] m_len,
   output logic            m_first,
   output logic            m_last,
   output logic            m_valid,
   input  logic            m_ready,
   output logic            len_err
);
   import hash_pkg::*;

   localparam logic [1:0] LAST_W = 2'(BLK_BYTES / 4 - 1);

   hkp_state_e      state_q, state_d;
   logic [LENW-1:0] len_q, len_d, cnt_q, cnt_d, bstart_q, bstart_d;
   logic [1:0]      widx_q, widx_d;
   logic [31:0]     w0_q, w0_d, w1_q, w1_d;
   logic            first_q, first_d, disc_q, disc_d, err_q, err_d;

   logic [31:0]     beat;
   logic [2:0]      popc;
   logic [LENW:0]   sum;
   logic [LENW-1:0] cnt_sat, hdr_clamp;
   logic            acc, done, load, free;
   key_blk_t        blk_in, blk_out;

   always_comb begin
      beat = '0;
      for (int i = 0; i < 4; i++)
         if (s_keep[i]) beat[8*i +: 8] = s_data[8*i +: 8];
   end

   assign popc      = 3'(s_keep[0]) + 3'(s_keep[1]) + 3'(s_keep[2]) + 3'(s_keep[3]);
   assign sum       = {1'b0, cnt_q} + (LENW+1)'(popc);
   assign cnt_sat   = sum[LENW] ? '1 : sum[LENW-1:0];
   assign hdr_clamp = (hdr_len > LENW'(MAXLEN)) ? LENW'(MAXLEN) : hdr_len;
   assign acc       = s_valid && s_ready;
   // Reaching the header length closes the key even without s_last (overflow path).
   assign done      = s_last || (cnt_sat >= len_q);

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      bstart_d  = bstart_q;
      widx_d    = widx_q;
      w0_d      = w0_q;
      w1_d      = w1_q;
      first_d   = first_q;
      disc_d    = disc_q;
      err_d     = 1'b0;
      hdr_ready = 1'b0;
      s_ready   = 1'b0;
      load      = 1'b0;
      blk_in    = '0;
      unique case (state_q)
         IDLE: begin
            hdr_ready = 1'b1;
            if (hdr_valid) begin
               len_d    = hdr_clamp;
               err_d    = hdr_len > LENW'(MAXLEN);
               cnt_d    = '0;
               bstart_d = '0;
               widx_d   = '0;
               w0_d     = '0;
               w1_d     = '0;
               first_d  = 1'b1;
               disc_d   = 1'b0;
               if (hdr_clamp == '0) begin
                  load         = 1'b1;
                  blk_in.first = 1'b1;
                  blk_in.last  = 1'b1;
                  state_d      = DRAIN;
               end else begin
                  state_d = COLLECT;
               end
            end
         end
         COLLECT: begin
            s_ready = free;
            if (acc) begin
               cnt_d = cnt_sat;
               if (widx_q == LAST_W || done) begin
                  load         = 1'b1;
                  blk_in.k0    = (widx_q == 2'd0) ? beat : w0_q;
                  blk_in.k1    = (widx_q == 2'd1) ? beat : ((widx_q == 2'd2) ? w1_q : '0);
                  blk_in.k2    = (widx_q == 2'd2) ? beat : '0;
                  blk_in.rem   = len_q - bstart_q;
                  blk_in.len   = len_q;
                  blk_in.first = first_q;
                  blk_in.last  = done;
                  bstart_d     = cnt_sat;
                  first_d      = 1'b0;
                  widx_d       = '0;
                  w0_d         = '0;
                  w1_d         = '0;
                  if (done) begin
                     state_d = DRAIN;
                     disc_d  = !s_last;
                     err_d   = s_last && (cnt_sat != len_q);
                  end
               end else begin
                  widx_d = widx_q + 2'd1;
                  if (widx_q == 2'd0) w0_d = beat;
                  else                w1_d = beat;
               end
            end
         end
         DRAIN: begin
            s_ready = disc_q;
            if (acc) begin
               cnt_d = cnt_sat;
               if (s_last) begin
                  disc_d = 1'b0;
                  err_d  = 1'b1;
               end
            end
            if (free && (!disc_q || (acc && s_last))) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         bstart_q <= '0;
         widx_q   <= '0;
         w0_q     <= '0;
         w1_q     <= '0;
         first_q  <= 1'b0;
         disc_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         bstart_q <= bstart_d;
         widx_q   <= widx_d;
         w0_q     <= w0_d;
         w1_q     <= w1_d;
         first_q  <= first_d;
         disc_q   <= disc_d;
         err_q    <= err_d;
      end
   end

   hash_blk_oreg u_oreg (
      .CLK     (CLK),
      .RST     (RST),
      .load_i  (load),
      .blk_i   (blk_in),
      .ready_i (m_ready),
      .valid_o (m_valid),
      .free_o  (free),
      .blk_o   (blk_out)
   );

   assign m_k0    = blk_out.k0;
   assign m_k1    = blk_out.k1;
   assign m_k2    = blk_out.k2;
   assign m_rem   = blk_out.rem;
   assign m_len   = blk_out.len;
   assign m_first = blk_out.first;
   assign m_last  = blk_out.last;
   assign len_err = err_q;
endmodule

// File: tb/tb_hash_key_packer.sv
// Directed and randomized checks of hash_key_packer against a byte-level block model.
`timescale 1ns/1ps
module tb_hash_key_packer;
   logic        CLK = 1'b0, RST = 1'b1;
   logic [7:0]  hdr_len = '0;
   logic        hdr_valid = 1'b0, hdr_ready;
   logic [31:0] s_data = '0;
   logic [3:0]  s_keep = '0;
   logic        s_last = 1'b0, s_valid = 1'b0, s_ready;
   logic [31:0] m_k0, m_k1, m_k2;
   logic [7:0]  m_rem, m_len;
   logic        m_first, m_last, m_valid, m_ready, len_err;

   typedef struct {
      logic [31:0] k0, k1, k2;
      logic [7:0]  rem, len;
      logic        first, last;
   } blk_s;

   blk_s        cap_q[$], exp_q[$];
   logic [31:0] bd_q[$];
   logic [3:0]  bk_q[$];
   int n_checks = 0, n_errors = 0, err_pulses = 0, sready_cnt = 0, rdy_mode = 0, gap_pct = 0;

   hash_key_packer dut (
      .CLK(CLK), .RST(RST), .hdr_len(hdr_len), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
      .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready),
      .m_k0(m_k0), .m_k1(m_k1), .m_k2(m_k2), .m_rem(m_rem), .m_len(m_len),
      .m_first(m_first), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready), .len_err(len_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      m_ready = 1'b1;
      forever begin
         @(posedge CLK); #1;
         case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = ($urandom_range(0, 99) < 60);
         endcase
      end
   end

   // Observer: blocks transfer on the posedge following a negedge with valid && ready.
   always @(negedge CLK) begin
      if (m_valid && m_ready) cap_q.push_back('{m_k0, m_k1, m_k2, m_rem, m_len, m_first, m_last});
      if (len_err) err_pulses++;
      if (s_ready) sready_cnt++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] seqw(input int n, input int lim);
      logic [31:0] w = '0;
      for (int l = 0; l < 4; l++) if (n + l < lim) w[8*l +: 8] = 8'(n + l);
      return w;
   endfunction

   task automatic make_key(input int nbytes, input bit seq);
      logic [31:0] d;
      logic [3:0]  k;
      bd_q.delete(); bk_q.delete();
      for (int b = 0; b < nbytes; b += 4) begin
         d = $urandom; k = '0;
         for (int l = 0; l < 4; l++)
            if (b + l < nbytes) begin k[l] = 1'b1; if (seq) d[8*l +: 8] = 8'(b + l); end
         bd_q.push_back(d); bk_q.push_back(k);
      end
   endtask

   // Splits the byte stream into 12-byte blocks at beat granularity; the key ends at the
   // stream's final beat or as soon as the header length is reached.
   function automatic int build_exp(input int hdr);
      int L = (hdr > 250) ? 250 : hdr;
      int errs = (hdr > 250) ? 1 : 0;
      int cnt = 0, start = 0, w = 0, n = bd_q.size();
      bit first = 1'b1, fin;
      logic [31:0] wd[3];
      logic [31:0] m;
      blk_s b;
      exp_q.delete();
      wd = '{32'h0, 32'h0, 32'h0};
      for (int i = 0; i < n; i++) begin
         m = '0;
         for (int l = 0; l < 4; l++) if (bk_q[i][l]) begin m[8*l +: 8] = bd_q[i][8*l +: 8]; cnt++; end
         wd[w] = m;
         fin = (i == n - 1) || (cnt >= L);
         if (w == 2 || fin) begin
            b = '{wd[0], wd[1], wd[2], 8'(L - start), 8'(L), first, fin};
            exp_q.push_back(b);
            first = 1'b0; start = cnt; w = 0; wd = '{32'h0, 32'h0, 32'h0};
            if (fin) begin
               if (i != n - 1 || cnt != L) errs++;
               break;
            end
         end else w++;
      end
      return errs;
   endfunction

   task automatic send_hdr(input logic [7:0] l);
      int t = 0;
      hdr_len = l; hdr_valid = 1'b1;
      @(negedge CLK);
      while (!hdr_ready && t < 3000) begin @(negedge CLK); t++; end
      n_checks++;
      if (!hdr_ready) begin n_errors++; $display("FAIL hdr_timeout hdr_ready=%b want 1", hdr_ready); end
      @(posedge CLK); #1;
      hdr_valid = 1'b0;
   endtask

   task automatic send_beats(input int from, input int to);
      int t;
      for (int i = from; i < to; i++) begin
         while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin s_valid = 1'b0; @(posedge CLK); #1; end
         s_valid = 1'b1; s_data = bd_q[i]; s_keep = bk_q[i]; s_last = (i == bd_q.size() - 1);
         t = 0;
         @(negedge CLK);
         while (!s_ready && t < 500) begin @(negedge CLK); t++; end
         n_checks++;
         if (!s_ready) begin
            n_errors++; $display("FAIL beat_timeout beat=%0d s_ready=%b want 1", i, s_ready);
            s_valid = 1'b0; s_last = 1'b0; @(posedge CLK); #1;
            return;
         end
         @(posedge CLK); #1;
      end
      s_valid = 1'b0; s_last = 1'b0; s_keep = '0;
   endtask

   task automatic wait_idle(input int base, input int n);
      int t = 0;
      while ((cap_q.size() < base + n || !hdr_ready) && t < 3000) begin @(negedge CLK); t++; end
      n_checks++;
      if (t >= 3000) begin n_errors++; $display("FAIL idle_timeout blocks=%0d want %0d", cap_q.size() - base, n); end
      repeat (3) @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_checks++; if (hdr_ready !== 1'b1) begin n_errors++; $display("FAIL rst_hdr_ready got %b want 1", hdr_ready); end
      n_checks++; if (s_ready !== 1'b0) begin n_errors++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
      n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
      n_checks++; if (len_err !== 1'b0) begin n_errors++; $display("FAIL rst_len_err got %b want 0", len_err); end
      n_checks++;
      if ({m_k0, m_k1, m_k2, m_rem, m_len, m_first, m_last} !== '0) begin
         n_errors++; $display("FAIL rst_block got %h %h %h rem=%0d len=%0d want all 0", m_k0, m_k1, m_k2, m_rem, m_len);
      end
      RST = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_exact12;
      int base = cap_q.size(), eb = err_pulses;
      rdy_mode = 0; gap_pct = 0;
      make_key(12, 1);
      send_hdr(8'd12);
      send_beats(0, 2);
      @(negedge CLK);
      n_checks++; if (m_valid !== 1'b0) begin n_errors++; $display("FAIL e12_early_valid got %b want 0", m_valid); end
      @(posedge CLK); #1;
      send_beats(2, 3);
      @(negedge CLK);
      n_checks++; if (m_valid !== 1'b1) begin n_errors++; $display("FAIL e12_latency m_valid got %b want 1", m_valid); end
      @(posedge CLK); #1;
      wait_idle(base, 1);
      n_checks++; if (cap_q.size() - base !== 1) begin n_errors++; $display("FAIL e12_count got %0d want 1", cap_q.size() - base); end
      n_checks++;
      if ({cap_q[base].k0, cap_q[base].k1, cap_q[base].k2} !== {32'h03020100, 32'h07060504, 32'h0B0A0908}) begin
         n_errors++; $display("FAIL e12_data got %h %h %h want 03020100 07060504 0b0a0908", cap_q[base].k0, cap_q[base].k1, cap_q[base].k2);
      end
      n_checks++;
      if ({cap_q[base].rem, cap_q[base].len, cap_q[base].first, cap_q[base].last} !== {8'd12, 8'd12, 2'b11}) begin
         n_errors++; $display("FAIL e12_tags got rem=%0d len=%0d f=%b l=%b want 12 12 1 1", cap_q[base].rem, cap_q[base].len, cap_q[base].first, cap_q[base].last);
      end
      n_checks++; if (err_pulses - eb !== 0) begin n_errors++; $display("FAIL e12_len_err got %0d want 0", err_pulses - eb); end
   endtask

   task automatic test_len13;
      int base = cap_q.size(), eb = err_pulses;
      make_key(13, 1);
      send_hdr(8'd13);
      send_beats(0, 4);
      wait_idle(base, 2);
      n_checks++; if (cap_q.size() - base !== 2) begin n_errors++; $display("FAIL l13_count got %0d want 2", cap_q.size() - base); end
      n_checks++;
      if ({cap_q[base].rem, cap_q[base].first, cap_q[base].last, cap_q[base].k2} !== {8'd13, 2'b10, 32'h0B0A0908}) begin
         n_errors++; $display("FAIL l13_blk0 got rem=%0d f=%b l=%b k2=%h want 13 1 0 0b0a0908", cap_q[base].rem, cap_q[base].first, cap_q[base].last, cap_q[base].k2);
      end
      n_checks++;
      if ({cap_q[base+1].k0, cap_q[base+1].k1, cap_q[base+1].k2, cap_q[base+1].rem, cap_q[base+1].first, cap_q[base+1].last} !==
          {32'h0000000C, 64'h0, 8'd1, 2'b01}) begin
         n_errors++; $display("FAIL l13_blk1 got %h %h %h rem=%0d f=%b l=%b want 0000000c 0 0 1 0 1", cap_q[base+1].k0, cap_q[base+1].k1,
                              cap_q[base+1].k2, cap_q[base+1].rem, cap_q[base+1].first, cap_q[base+1].last);
      end
      n_checks++; if (err_pulses - eb !== 0) begin n_errors++; $display("FAIL l13_len_err got %0d want 0", err_pulses - eb); end
   endtask

   task automatic test_zero;
      int base = cap_q.size(), eb = err_pulses, sb = sready_cnt;
      send_hdr(8'd0);
      wait_idle(base, 1);
      n_checks++; if (cap_q.size() - base !== 1) begin n_errors++; $display("FAIL zero_count got %0d want 1", cap_q.size() - base); end
      n_checks++;
      if ({cap_q[base].k0, cap_q[base].k1, cap_q[base].k2, cap_q[base].rem, cap_q[base].len, cap_q[base].first, cap_q[base].last} !==
          {112'h0, 2'b11}) begin
         n_errors++; $display("FAIL zero_block got %h %h %h rem=%0d f=%b l=%b want 0 0 0 0 1 1", cap_q[base].k0, cap_q[base].k1,
                              cap_q[base].k2, cap_q[base].rem, cap_q[base].first, cap_q[base].last);
      end
      n_checks++; if (sready_cnt - sb !== 0) begin n_errors++; $display("FAIL zero_s_ready cycles got %0d want 0", sready_cnt - sb); end
      n_checks++; if (err_pulses - eb !== 0) begin n_errors++; $display("FAIL zero_len_err got %0d want 0", err_pulses - eb); end
   endtask

   task automatic test_overflow;
      int base = cap_q.size(), eb = err_pulses;
      make_key(12, 1);
      send_hdr(8'd8);
      send_beats(0, 2);
      @(negedge CLK);
      n_checks++;
      if ({m_valid, m_last} !== 2'b11) begin n_errors++; $display("FAIL ovf_early_last got v=%b l=%b want 1 1", m_valid, m_last); end
      @(posedge CLK); #1;
      send_beats(2, 3);
      wait_idle(base, 1);
      n_checks++; if (cap_q.size() - base !== 1) begin n_errors++; $display("FAIL ovf_count got %0d want 1", cap_q.size() - base); end
      n_checks++;
      if ({cap_q[base].k0, cap_q[base].k1, cap_q[base].k2, cap_q[base].rem, cap_q[base].last} !==
          {32'h03020100, 32'h07060504, 32'h0, 8'd8, 1'b1}) begin
         n_errors++; $display("FAIL ovf_block got %h %h %h rem=%0d l=%b want 03020100 07060504 0 8 1", cap_q[base].k0,
                              cap_q[base].k1, cap_q[base].k2, cap_q[base].rem, cap_q[base].last);
      end
      n_checks++; if (err_pulses - eb !== 1) begin n_errors++; $display("FAIL ovf_len_err got %0d want 1", err_pulses - eb); end
   endtask

   task automatic test_max_bp;
      int base = cap_q.size(), eb = err_pulses;
      blk_s g;
      rdy_mode = 1;
      make_key(250, 1);
      send_hdr(8'd250);
      send_beats(0, 63);
      wait_idle(base, 21);
      rdy_mode = 0;
      n_checks++; if (cap_q.size() - base !== 21) begin n_errors++; $display("FAIL max_count got %0d want 21", cap_q.size() - base); end
      for (int b = 0; b < 21 && base + b < cap_q.size(); b++) begin
         g = cap_q[base + b];
         n_checks++;
         if ({g.k0, g.k1, g.k2, g.rem, g.len, g.first, g.last} !==
             {seqw(12*b, 250), seqw(12*b + 4, 250), seqw(12*b + 8, 250), 8'(250 - 12*b), 8'd250, b == 0, b == 20}) begin
            n_errors++; $display("FAIL max_blk%0d got %h %h %h rem=%0d f=%b l=%b want %h %h %h rem=%0d", b, g.k0, g.k1, g.k2,
                                 g.rem, g.first, g.last, seqw(12*b, 250), seqw(12*b + 4, 250), seqw(12*b + 8, 250), 250 - 12*b);
         end
      end
      n_checks++; if (err_pulses - eb !== 0) begin n_errors++; $display("FAIL max_len_err got %0d want 0", err_pulses - eb); end
   endtask

   task automatic test_reset_midkey;
      int base, eb = err_pulses;
      rdy_mode = 0;
      make_key(24, 1);
      send_hdr(8'd24);
      send_beats(0, 2);
      RST = 1'b1;
      @(posedge CLK); #1;
      @(negedge CLK);
      n_checks++;
      if ({m_valid, hdr_ready, s_ready} !== 3'b010) begin
         n_errors++; $display("FAIL midrst_state got v=%b hr=%b sr=%b want 0 1 0", m_valid, hdr_ready, s_ready);
      end
      RST = 1'b0;
      @(posedge CLK); #1;
      base = cap_q.size();
      make_key(4, 1);
      send_hdr(8'd4);
      send_beats(0, 1);
      wait_idle(base, 1);
      n_checks++; if (cap_q.size() - base !== 1) begin n_errors++; $display("FAIL midrst_count got %0d want 1", cap_q.size() - base); end
      n_checks++;
      if ({cap_q[base].k0, cap_q[base].k1, cap_q[base].k2, cap_q[base].rem, cap_q[base].first, cap_q[base].last} !==
          {32'h03020100, 64'h0, 8'd4, 2'b11}) begin
         n_errors++; $display("FAIL midrst_block got %h %h %h rem=%0d f=%b l=%b want 03020100 0 0 4 1 1", cap_q[base].k0,
                              cap_q[base].k1, cap_q[base].k2, cap_q[base].rem, cap_q[base].first, cap_q[base].last);
      end
      n_checks++; if (err_pulses - eb !== 0) begin n_errors++; $display("FAIL midrst_len_err got %0d want 0", err_pulses - eb); end
   endtask

   task automatic test_random;
      int base, eb, hdr, nb, xerr;
      blk_s g, e;
      rdy_mode = 2; gap_pct = 30;
      for (int k = 0; k < 40; k++) begin
         hdr = ($urandom_range(0, 5) == 0) ? $urandom_range(240, 255) : $urandom_range(1, 80);
         case ($urandom_range(0, 2))
            0:       nb = (hdr > 250) ? 250 : hdr;
            1:       nb = hdr - $urandom_range(1, 6);
            default: nb = hdr + $urandom_range(1, 6);
         endcase
         if (nb < 1) nb = 1;
         make_key(nb, 1'b0);
         xerr = build_exp(hdr);
         base = cap_q.size(); eb = err_pulses;
         send_hdr(8'(hdr));
         send_beats(0, bd_q.size());
         wait_idle(base, exp_q.size());
         n_checks++;
         if (cap_q.size() - base !== exp_q.size()) begin
            n_errors++; $display("FAIL rnd%0d_count hdr=%0d bytes=%0d got %0d want %0d", k, hdr, nb, cap_q.size() - base, exp_q.size());
         end
         for (int b = 0; b < exp_q.size() && base + b < cap_q.size(); b++) begin
            g = cap_q[base + b]; e = exp_q[b];
            n_checks++;
            if ({g.k0, g.k1, g.k2, g.rem, g.len, g.first, g.last} !== {e.k0, e.k1, e.k2, e.rem, e.len, e.first, e.last}) begin
               n_errors++; $display("FAIL rnd%0d_blk%0d got %h %h %h r=%0d n=%0d f=%b l=%b want %h %h %h r=%0d n=%0d f=%b l=%b", k, b,
                                    g.k0, g.k1, g.k2, g.rem, g.len, g.first, g.last, e.k0, e.k1, e.k2, e.rem, e.len, e.first, e.last);
            end
         end
         n_checks++;
         if (err_pulses - eb !== xerr) begin
            n_errors++; $display("FAIL rnd%0d_len_err hdr=%0d bytes=%0d got %0d want %0d", k, hdr, nb, err_pulses - eb, xerr);
         end
      end
      rdy_mode = 0; gap_pct = 0;
   endtask

   initial begin
      test_reset;
      test_exact12;
      test_len13;
      test_zero;
      test_overflow;
      test_max_bp;
      test_reset_midkey;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/hash_key_packer.md
Name: hash_key_packer

Overview:
- Upstream feeder for the Jenkins lookup3 hash pipeline.
- Takes the key length from the memcache request header, then a 32-bit key byte stream.
- Emits 96-bit key blocks (k0, k1, k2) in hashlittle byte order, each tagged with the remaining byte count the hash rounds consume as their word/length field.
- One key in flight. Output is a valid/ready stream with a single-block output register.

Parameters:
- MAXLEN, 250, maximum key length in bytes; larger header lengths are clamped and flagged.
- LENW, 8, width of length and remaining-count fields.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- hdr_len  in  LENW  key length from the protocol header
- hdr_valid  in  1  header length valid
- hdr_ready  out  1  header accepted (idle only)
- s_data  in  32  key bytes; lane 0 (bits 7:0) is the earliest byte
- s_keep  in  4  byte valid mask; contiguous from lane 0; partial only on the last beat
- s_last  in  1  final beat of the key
- s_valid  in  1  key beat valid
- s_ready  out  1  key beat accepted
- m_k0, m_k1, m_k2  out  32 each  key block; byte n of the block is at k(n/4)[8*(n%4)+7 : 8*(n%4)]
- m_rem  out  LENW  key bytes remaining at the start of this block (key_len − 12·blk)
- m_len  out  LENW  total key length, held for the whole key
- m_first  out  1  first block of the key
- m_last  out  1  final block of the key
- m_valid  out  1  block valid
- m_ready  in  1  downstream accepts block
- len_err  out  1  one-cycle pulse: stream byte count ≠ header length, or header length > MAXLEN

Behaviour:
- Reset values: all outputs 0 except hdr_ready=1. Collection buffer cleared. State IDLE.
- FSM states: IDLE, COLLECT, DRAIN.
  - IDLE:
    - hdr_ready=1, s_ready=0.
    - On hdr_valid: latch len = min(hdr_len, MAXLEN); pulse len_err next cycle if hdr_len > MAXLEN; reset byte count and word index.
    - len==0: go to DRAIN and emit one all-zero block with rem=0, first=last=1. No key beats are consumed.
    - Otherwise go to COLLECT.
  - COLLECT:
    - s_ready = !(m_valid && !m_ready).
    - Each accepted beat writes word index w (0..2). Lanes with keep=0 are written as zero.
    - Byte count += popcount(keep).
    - A block closes when w==2 is written, or on s_last. Unwritten words in a closing block are zero.
  - Block transfer:
    - A closed block moves to the output register in the same cycle it closes.
    - rem = len − bytes before this block.
    - first set if it is block 0.
    - last set if s_last, or if byte count ≥ len.
    - Output latency: one cycle from the closing beat to m_valid.
  - Overflow: if byte count reaches len before s_last, the packer emits the block as last, then enters DRAIN and discards beats (s_ready=1) until s_last, then pulses len_err.
  - Underflow: s_last with byte count < len sets last=1 and pulses len_err in the same cycle m_valid rises.
  - DRAIN: waits for the last block to be accepted (m_valid && m_ready) and any discard to finish, then returns to IDLE. hdr_ready stays 0 until then.
- Output register:
  - m_* holds stable while m_valid && !m_ready.
  - Cleared valid on accept unless a new block loads in the same cycle (back-to-back, full throughput: one beat per cycle).
- Arithmetic:
  - Byte count and rem use LENW bits. With MAXLEN ≤ 250, byte count cannot wrap; count saturates at 255 while discarding.
- Reset mid-key: the key is dropped, m_valid drops the next cycle, and nothing is flagged.
- A new header is ignored while not IDLE.

Decomposition:
- Shared package hash_pkg:
  - constants JHASH_INIT=32'hDEADBEEF, BLK_BYTES=12, MAXLEN.
  - FSM state typedef.
  - key block struct {k0, k1, k2, rem, len, first, last}, reused by the hash stage's input.
- One sub-module: hash_blk_oreg, a single-entry valid/ready output register carrying the block struct.

Test Plan:
- hdr_len=12, three full beats 0x03020100, 0x07060504, 0x0B0A0908 with last on the third → one block, k0=0x03020100, k2=0x0B0A0908, rem=12, first=last=1, m_valid one cycle after the third beat, len_err=0.
- hdr_len=13, four beats, final keep=4'b0001 data 0xXXXXXX0C → block 0 with rem=13, last=0; block 1 with k0=0x0000000C, k1=k2=0, rem=1, last=1.
- hdr_len=0 → one zero block, rem=0, first=last=1; s_ready never asserts.
- hdr_len=8, beats carry 12 bytes with s_last on beat 3 → block rem=8, last=1 emitted after beat 2; beat 3 discarded; len_err pulses once.
- hdr_len=250, 63 beats, m_ready toggling 1,0,1,0 → 21 blocks with rem 250, 238, …, 10; no beat lost or duplicated; the final block has k2[31:16]=0.
- hdr_len=24, RST asserted after beat 2 → next cycle m_valid=0, hdr_ready=1; a following hdr_len=4 key completes normally.
